// File: rtl/um_ctrl_pkg.sv
// Shared parameters and FSM state encoding for the um_ctrl sort controller.
package um_ctrl_pkg;

   localparam int ELEMENT_NUM      = 4;
   localparam int DATA_WIDTH       = 8;
   // One bit wider than a bare index so that an out-of-range rank index can be
   // represented and flagged, and so the issue counter can hold ELEMENT_NUM.
   localparam int LOG2_ELEMENT_NUM = $clog2(ELEMENT_NUM) + 1;
   localparam int LOG2_DATA_WIDTH  = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SCAN = 3'd2,
      ST_OUT  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/um_ctrl.sv
// Unary-memory sort controller: loads ELEMENT_NUM elements into an external
// memory, walks the bit columns MSB first for the sorting core, then reads the
// elements back in the rank order returned by the core.
//
// Handshakes: every channel is valid/ready; a transfer happens in exactly the
// cycles where both are high at the rising edge. in_ready, rank_ready and
// scan_valid never depend on the partner's valid/ack in the same direction;
// rank_ready does depend on out_ready so output and rank stages can overlap.
module um_ctrl
   import um_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic                        um_wr_en,
   output logic [DATA_WIDTH-1:0]       um_wr_data,
   output logic [LOG2_ELEMENT_NUM-1:0] um_addr,
   output logic [LOG2_DATA_WIDTH-1:0]  um_bit_addr,
   input  logic [DATA_WIDTH-1:0]       um_rd_data,
   output logic                        scan_valid,
   input  logic                        scan_ack,
   input  logic                        rank_valid,
   input  logic [LOG2_ELEMENT_NUM-1:0] rank_idx,
   output logic                        rank_ready,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [2:0]                  fsm_state
);

   localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_WR  = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
   localparam logic [LOG2_ELEMENT_NUM-1:0] ELEM_CNT = LOG2_ELEMENT_NUM'(ELEMENT_NUM);
   localparam logic [LOG2_DATA_WIDTH-1:0]  MSB_COL  = LOG2_DATA_WIDTH'(DATA_WIDTH - 1);

   state_t                      state_q, state_d;
   logic [LOG2_ELEMENT_NUM-1:0] wr_cnt;
   logic [LOG2_ELEMENT_NUM-1:0] issued;
   logic                        accept_rank;
   logic                        consume;

   assign fsm_state = state_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      scan_valid  = 1'b0;
      rank_ready  = 1'b0;
      done        = 1'b0;
      um_addr     = wr_cnt;
      um_wr_data  = in_data;
      busy        = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE, ST_LOAD: begin
            in_ready = !rst;
            if (in_valid && in_ready)
               state_d = (wr_cnt == LAST_WR) ? ST_SCAN : ST_LOAD;
         end
         ST_SCAN: begin
            scan_valid = !rst;
            if (scan_ack && !rst && (um_bit_addr == '0))
               state_d = ST_OUT;
         end
         ST_OUT: begin
            um_addr    = rank_idx;
            rank_ready = !rst && (!out_valid || out_ready) && (issued < ELEM_CNT);
            // The last element is pending once everything has been issued.
            if (out_valid && out_ready && (issued == ELEM_CNT))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = !rst;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      um_wr_en    = in_valid && in_ready;
      accept_rank = rank_valid && rank_ready;
      consume     = out_valid && out_ready;
   end

   // Counters, bit-column pointer, output register and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt      <= '0;
         issued      <= '0;
         um_bit_addr <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         err         <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (um_wr_en) begin
                  if (wr_cnt == LAST_WR) begin
                     wr_cnt      <= '0;
                     um_bit_addr <= MSB_COL;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (scan_ack && (um_bit_addr != '0))
                  um_bit_addr <= um_bit_addr - 1'b1;
            end
            ST_OUT: begin
               if (accept_rank) begin
                  out_data  <= um_rd_data;
                  out_valid <= 1'b1;
                  issued    <= issued + 1'b1;
                  if (rank_idx >= ELEM_CNT) err <= 1'b1;
               end else if (consume) begin
                  out_valid <= 1'b0;
               end
            end
            ST_DONE: begin
               wr_cnt      <= '0;
               issued      <= '0;
               um_bit_addr <= '0;
               out_valid   <= 1'b0;
            end
            default: begin
               wr_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_um_ctrl.sv
// Self-checking bench for um_ctrl with a behavioural memory and sorting core.
module tb_um_ctrl;
   import um_ctrl_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        in_valid;
   logic [DATA_WIDTH-1:0]       in_data;
   logic                        in_ready;
   logic                        um_wr_en;
   logic [DATA_WIDTH-1:0]       um_wr_data;
   logic [LOG2_ELEMENT_NUM-1:0] um_addr;
   logic [LOG2_DATA_WIDTH-1:0]  um_bit_addr;
   logic [DATA_WIDTH-1:0]       um_rd_data;
   logic                        scan_valid;
   logic                        scan_ack;
   logic                        rank_valid;
   logic [LOG2_ELEMENT_NUM-1:0] rank_idx;
   logic                        rank_ready;
   logic                        out_valid;
   logic [DATA_WIDTH-1:0]       out_data;
   logic                        out_ready;
   logic                        busy;
   logic                        done;
   logic                        err;
   logic [2:0]                  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_err  = 1'b0;

   logic [DATA_WIDTH-1:0] mem [8] = '{default: '0};

   um_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .um_wr_en(um_wr_en), .um_wr_data(um_wr_data), .um_addr(um_addr),
      .um_bit_addr(um_bit_addr), .um_rd_data(um_rd_data), .scan_valid(scan_valid),
      .scan_ack(scan_ack), .rank_valid(rank_valid), .rank_idx(rank_idx),
      .rank_ready(rank_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // External element memory with combinational read.
   always @(posedge clk) begin
      if (um_wr_en) mem[um_addr] <= um_wr_data;
   end
   assign um_rd_data = mem[um_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = '0; scan_ack = 1'b0;
      rank_valid = 1'b0; rank_idx = '0; out_ready = 1'b0;
   endtask

   // mode 0: directed (ack every other cycle, always ready/valid)
   // mode 1: random handshakes; mode 2: random plus a 3-cycle out_ready stall
   task automatic run_sort(input logic [7:0] vals [4], input int mode, input int bad_pos);
      logic [7:0] exp_q[$];
      logic [LOG2_ELEMENT_NUM-1:0] rank_q[$];
      bit used [4];
      int best, exp_bit, cyc, consumed, issued_m;
      bit ov_m, acc, cons, exp_rr, ack_tog;

      // Load phase, optional idle gaps between writes.
      for (int i = 0; i < 4; i++) begin
         if (mode != 0 && $urandom_range(0, 2) == 0) begin
            @(negedge clk); in_valid = 1'b0; #1;
            chk("gap_wr_en", um_wr_en, 0);
         end
         @(negedge clk); in_valid = 1'b1; in_data = vals[i]; #1;
         chk("wr_en", um_wr_en, 1);
         chk("wr_addr", um_addr, i);
         chk("wr_data", um_wr_data, vals[i]);
      end

      // First SCAN cycle: inputs and ranks must be refused.
      @(negedge clk); in_valid = 1'b1; in_data = 8'hAA; rank_valid = 1'b1; rank_idx = '0; #1;
      chk("scan_valid_first", scan_valid, 1);
      chk("scan_in_ready", in_ready, 0);
      chk("scan_wr_en", um_wr_en, 0);
      chk("scan_rank_ready", rank_ready, 0);
      chk("scan_bit_msb", um_bit_addr, 7);
      exp_bit = 7; cyc = 0; ack_tog = 1'b0;

      while (cyc < 100) begin
         @(negedge clk);
         in_valid = 1'b0; rank_valid = 1'b0;
         scan_ack = (mode != 0) ? 1'($urandom_range(0, 1)) : ack_tog;
         ack_tog = !ack_tog;
         #1;
         chk("scan_bit", um_bit_addr, exp_bit);
         chk("scan_valid", scan_valid, 1);
         if (scan_ack) begin
            if (exp_bit == 0) break;
            exp_bit--;
         end
         cyc++;
      end
      chk("scan_timeout", (cyc < 100), 1);

      // Reference order: smallest signed value first, ties by lower index.
      for (int k = 0; k < 4; k++) begin
         best = -1;
         for (int j = 0; j < 4; j++)
            if (!used[j] && (best < 0 || $signed(vals[j]) < $signed(vals[best]))) best = j;
         used[best] = 1'b1;
         rank_q.push_back(LOG2_ELEMENT_NUM'(best));
      end
      if (bad_pos >= 0) begin
         rank_q[bad_pos] = 3'd5;
         exp_err = 1'b1;
      end

      consumed = 0; issued_m = 0; ov_m = 1'b0; cyc = 0;
      while (consumed < 4 && cyc < 300) begin
         @(negedge clk);
         scan_ack = 1'b0;
         out_ready = (mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mode == 2 && cyc >= 2 && cyc < 5) out_ready = 1'b0;
         rank_valid = (rank_q.size() > 0) && ((mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (rank_q.size() > 0) rank_idx = rank_q[0];
         else rank_idx = '0;
         #1;
         exp_rr = (!ov_m || out_ready) && (issued_m < 4);
         chk("rank_ready", rank_ready, exp_rr);
         chk("out_valid", out_valid, ov_m);
         chk("done_early", done, 0);
         chk("out_busy", busy, 1);
         if (rank_valid) chk("rd_addr", um_addr, rank_idx);
         if (ov_m) chk("out_data", out_data, exp_q[0]);
         cons = ov_m && out_ready;
         acc  = rank_valid && exp_rr;
         if (cons) begin
            void'(exp_q.pop_front());
            consumed++;
         end
         if (acc) begin
            exp_q.push_back((rank_idx < 4) ? vals[rank_idx[1:0]] : 8'h00);
            void'(rank_q.pop_front());
            issued_m++;
         end
         ov_m = acc ? 1'b1 : (cons ? 1'b0 : ov_m);
         cyc++;
      end
      chk("out_timeout", consumed, 4);

      @(negedge clk); rank_valid = 1'b0; out_ready = 1'b0; #1;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_out_valid", out_valid, 0);
      chk("done_err", err, exp_err);
      @(negedge clk); #1;
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_bit", um_bit_addr, 0);
      chk("idle_err", err, exp_err);
   endtask

   // Directed and randomized sequence.
   initial begin
      logic [7:0] v [4];
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk); in_valid = 1'b1; in_data = 8'h11; #1;
      chk("rst_wr_en", um_wr_en, 0);
      chk("rst_scan_valid", scan_valid, 0);
      chk("rst_rank_ready", rank_ready, 0);
      @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      chk("rst_done", done, 0);
      chk("rst_bit", um_bit_addr, 0);
      chk("rst_in_ready", in_ready, 1);

      // Abort after two loads.
      @(negedge clk); in_valid = 1'b1; in_data = 8'h21;
      @(negedge clk); in_data = 8'h22;
      @(negedge clk); in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);

      v = '{8'd5, 8'hFD, 8'd7, 8'd0};
      run_sort(v, 0, -1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
         run_sort(v, 1, -1);
      end

      for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
      run_sort(v, 2, 1);

      for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
      run_sort(v, 1, -1);

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; exp_err = 1'b0; #1;
      chk("err_cleared", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
